// File: rtl/uart_wb_echo_master.sv
// uart_wb_echo_master: Wishbone master that initialises a 16550 UART, then echoes received bytes back out.
module uart_wb_echo_master #(
  parameter logic [15:0] DIVISOR   = 16'd27,
  parameter logic [7:0]  LCR_VALUE = 8'h03,
  parameter logic [7:0]  FCR_VALUE = 8'hC6,
  parameter logic [7:0]  XOR_MASK  = 8'h00,
  parameter int          TIMEOUT   = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       echo_en_i,
  output logic [4:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  output logic [3:0] wb_sel_o,
  input  logic       wb_ack_i,
  output logic       init_done_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic [7:0] echo_count_o,
  output logic       bus_err_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {
    INIT_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR, POLL_RX, READ_RBR, POLL_TX, WRITE_THR
  } state_t;
  state_t state, state_d;
  logic act, act_d, we, we_d, tmo_hit;
  logic [TW-1:0] tmo, tmo_d;
  logic [2:0] adr, adr_d, acc_adr;
  logic [7:0] dat, dat_d, acc_dat;
  logic acc_we;
  logic init_done_d, rx_valid_d, err_d;
  logic [7:0] rx_byte_d, count_d;
  assign wb_cyc_o = act;
  assign wb_stb_o = act;
  assign wb_adr_o = {2'b00, adr};
  assign wb_dat_o = dat;
  assign wb_we_o  = we;
  assign wb_sel_o = 4'b0001;
  // Address, data and direction of the access each state issues
  always_comb begin
    acc_adr = 3'd0;
    acc_dat = 8'h00;
    acc_we  = 1'b0;
    case (state)
      INIT_DLAB:        {acc_adr, acc_dat, acc_we} = {3'd3, 8'h80, 1'b1};
      INIT_DLL:         {acc_adr, acc_dat, acc_we} = {3'd0, DIVISOR[7:0], 1'b1};
      INIT_DLM:         {acc_adr, acc_dat, acc_we} = {3'd1, DIVISOR[15:8], 1'b1};
      INIT_LCR:         {acc_adr, acc_dat, acc_we} = {3'd3, LCR_VALUE, 1'b1};
      INIT_FCR:         {acc_adr, acc_dat, acc_we} = {3'd2, FCR_VALUE, 1'b1};
      POLL_RX, POLL_TX: acc_adr = 3'd5;
      WRITE_THR:        {acc_adr, acc_dat, acc_we} = {3'd0, rx_byte_o ^ XOR_MASK, 1'b1};
      default: ;
    endcase
  end
  // A timed-out access finishes like an ack but never takes the success path
  always_comb begin
    state_d     = state;
    act_d       = act;
    tmo_d       = tmo;
    adr_d       = adr;
    dat_d       = dat;
    we_d        = we;
    init_done_d = init_done_o;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte_o;
    count_d     = echo_count_o;
    err_d       = bus_err_o;
    tmo_hit     = act && !wb_ack_i && tmo == TW'(TIMEOUT - 1);
    if (!act && !(state == POLL_RX && !echo_en_i)) begin
      act_d = 1'b1;
      tmo_d = '0;
      adr_d = acc_adr;
      dat_d = acc_dat;
      we_d  = acc_we;
    end else if (act && (wb_ack_i || tmo_hit)) begin
      act_d = 1'b0;
      err_d = bus_err_o | tmo_hit;
      case (state)
        INIT_DLAB: state_d = INIT_DLL;
        INIT_DLL:  state_d = INIT_DLM;
        INIT_DLM:  state_d = INIT_LCR;
        INIT_LCR:  state_d = INIT_FCR;
        INIT_FCR: begin
          state_d     = POLL_RX;
          init_done_d = 1'b1;
        end
        POLL_RX:   state_d = (wb_ack_i && wb_dat_i[0]) ? READ_RBR : POLL_RX;
        READ_RBR: begin
          state_d    = wb_ack_i ? POLL_TX : POLL_RX;
          rx_valid_d = wb_ack_i;
          rx_byte_d  = wb_ack_i ? wb_dat_i : rx_byte_o;
        end
        POLL_TX:   state_d = wb_ack_i ? (wb_dat_i[5] ? WRITE_THR : POLL_TX) : POLL_RX;
        WRITE_THR: begin
          state_d = POLL_RX;
          count_d = echo_count_o + {7'd0, wb_ack_i};
        end
        default:   state_d = INIT_DLAB;
      endcase
    end else if (act) tmo_d = tmo + 1'b1;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= INIT_DLAB;
      act          <= 1'b0;
      tmo          <= '0;
      adr          <= '0;
      dat          <= '0;
      we           <= 1'b0;
      init_done_o  <= 1'b0;
      rx_valid_o   <= 1'b0;
      rx_byte_o    <= '0;
      echo_count_o <= '0;
      bus_err_o    <= 1'b0;
    end else begin
      state        <= state_d;
      act          <= act_d;
      tmo          <= tmo_d;
      adr          <= adr_d;
      dat          <= dat_d;
      we           <= we_d;
      init_done_o  <= init_done_d;
      rx_valid_o   <= rx_valid_d;
      rx_byte_o    <= rx_byte_d;
      echo_count_o <= count_d;
      bus_err_o    <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_wb_echo_master.sv
// tb_uart_wb_echo_master: behavioural UART slave plus vector tables and random echo traffic.
module tb_uart_wb_echo_master;
  localparam logic [7:0] MASK = 8'h20;
  logic clk = 1'b0, rst = 1'b1, echo_en = 1'b0;
  logic [4:0] adr;
  logic [7:0] dat, rdat = 8'h00;
  logic we, stb, cyc, ack = 1'b0;
  logic [3:0] sel;
  logic init_done, rx_valid, bus_err;
  logic [7:0] rx_byte, echo_count;
  int errors = 0, checks = 0;
  typedef struct {logic we; logic [4:0] adr; logic [7:0] dat;} acc_t;
  typedef struct {logic [4:0] adr; logic [7:0] dat;} wr_t;
  typedef struct {logic [7:0] d; int busy; logic [7:0] thr;} vec_t;
  acc_t alog[$];
  logic [7:0] txlog[$], rxq[$], exp_rx[$], exp_tx[$];
  logic thre_q[$];
  int ack_dly = 0, wcnt = 0;
  bit no_ack_dlm = 1'b0, thre_rand = 1'b0;
  wr_t init_tab[5];
  vec_t vt[5];

  always #5 clk = ~clk;

  uart_wb_echo_master #(.XOR_MASK(MASK)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .echo_en_i(echo_en),
    .wb_adr_o(adr), .wb_dat_o(dat), .wb_dat_i(rdat), .wb_we_o(we),
    .wb_stb_o(stb), .wb_cyc_o(cyc), .wb_sel_o(sel), .wb_ack_i(ack),
    .init_done_o(init_done), .rx_valid_o(rx_valid), .rx_byte_o(rx_byte),
    .echo_count_o(echo_count), .bus_err_o(bus_err)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic thre_bit();
    if (thre_q.size() != 0) return thre_q.pop_front();
    return thre_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // UART model: LSR[0] = receive queue non-empty, LSR[5] = transmitter ready
  always @(posedge clk) begin
    if (rst || ack || !(cyc && stb)) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (wcnt < ack_dly || (no_ack_dlm && we && adr == 5'd1)) wcnt <= wcnt + 1;
    else begin
      ack <= 1'b1;
      alog.push_back('{we, adr, dat});
      if (we && adr == 5'd0) txlog.push_back(dat);
      if (!we && adr == 5'd5) rdat <= {1'b0, 1'b0, thre_bit(), 4'b0000, rxq.size() != 0};
      else if (!we && adr == 5'd0 && rxq.size() != 0) rdat <= rxq.pop_front();
      else rdat <= 8'h00;
    end
  end

  logic p_cyc = 1'b0, p_ack = 1'b0, p_rst = 1'b1, p_we = 1'b0;
  logic [4:0] p_adr = 5'd0;
  logic [7:0] p_dat = 8'h00;
  always @(negedge clk) begin
    if (!rst && !p_rst) begin
      chk("stb_eq_cyc", stb, cyc);
      chk("sel", sel, 4'b0001);
      if (p_cyc && !p_ack && cyc) chk("hold", {we, adr, dat}, {p_we, p_adr, p_dat});
      if (p_cyc && p_ack) chk("idle_gap", cyc, 1'b0);
    end
    if (!rst && rx_valid) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got byte %0h, none expected", rx_byte);
      end else chk("rx_byte", rx_byte, exp_rx.pop_front());
    end
    p_cyc <= cyc;
    p_ack <= ack;
    p_rst <= rst;
    p_we  <= we;
    p_adr <= adr;
    p_dat <= dat;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c0, tx0, base;
    logic [7:0] d;
    init_tab[0] = '{5'd3, 8'h80};
    init_tab[1] = '{5'd0, 8'h1B};
    init_tab[2] = '{5'd1, 8'h00};
    init_tab[3] = '{5'd3, 8'h03};
    init_tab[4] = '{5'd2, 8'hC6};
    vt[0] = '{8'h41, 0, 8'h61};
    vt[1] = '{8'h41, 3, 8'h61};
    vt[2] = '{8'h00, 1, 8'h20};
    vt[3] = '{8'hFF, 2, 8'hDF};
    vt[4] = '{8'h20, 0, 8'h00};
    repeat (3) @(negedge clk);
    chk("rst_cyc", cyc, 0); chk("rst_stb", stb, 0); chk("rst_we", we, 0);
    chk("rst_adr", adr, 0); chk("rst_dat", dat, 0); chk("rst_done", init_done, 0);
    chk("rst_rxv", rx_valid, 0); chk("rst_rxb", rx_byte, 0); chk("rst_cnt", echo_count, 0);
    chk("rst_err", bus_err, 0); chk("rst_sel", sel, 4'b0001);
    rst = 1'b0;
    for (int k = 0; k < 300 && !init_done; k++) @(negedge clk);
    chk("init_done", init_done, 1);
    chk("init_n", alog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < alog.size())
        chk($sformatf("init%0d", i), {alog[i].we, alog[i].adr, alog[i].dat}, {1'b1, init_tab[i].adr, init_tab[i].dat});
    repeat (20) @(negedge clk);
    chk("idle_n", alog.size(), 5);
    chk("idle_err", bus_err, 0);
    // Each vector drops echo_en as soon as the byte is read; the echo must still complete
    for (int i = 0; i < 5; i++) begin
      alog.delete();
      thre_q.push_back(1'b0);
      for (int b = 0; b < vt[i].busy; b++) thre_q.push_back(1'b0);
      thre_q.push_back(1'b1);
      rxq.push_back(vt[i].d);
      exp_rx.push_back(vt[i].d);
      c0 = echo_count;
      tx0 = txlog.size();
      echo_en = 1'b1;
      for (int k = 0; k < 200 && !rx_valid; k++) @(negedge clk);
      chk($sformatf("v%0d_rxv", i), rx_valid, 1);
      echo_en = 1'b0;
      for (int k = 0; k < 300 && echo_count == c0; k++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_cnt", i), echo_count, i + 1);
      chk($sformatf("v%0d_thr_n", i), txlog.size(), tx0 + 1);
      if (txlog.size() > tx0) chk($sformatf("v%0d_thr", i), txlog[tx0], vt[i].thr);
      chk($sformatf("v%0d_acc", i), alog.size(), vt[i].busy + 4);
      chk($sformatf("v%0d_rxb", i), rx_byte, vt[i].d);
    end
    base = txlog.size();
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom_range(0, 255));
      rxq.push_back(d);
      exp_rx.push_back(d);
      exp_tx.push_back(d ^ MASK);
    end
    thre_rand = 1'b1;
    ack_dly = 1;
    echo_en = 1'b1;
    for (int k = 0; k < 8000 && txlog.size() < base + 24; k++) @(negedge clk);
    echo_en = 1'b0;
    repeat (8) @(negedge clk);
    chk("rand_n", txlog.size(), base + 24);
    for (int k = 0; k < 24; k++)
      if (base + k < txlog.size()) chk($sformatf("rand_thr%0d", k), txlog[base + k], exp_tx[k]);
    chk("rand_cnt", echo_count, 29);
    thre_rand = 1'b0;
    ack_dly = 0;
    base = txlog.size();
    for (int k = 0; k < 227; k++) begin
      d = 8'($urandom_range(0, 255));
      rxq.push_back(d);
      exp_rx.push_back(d);
    end
    echo_en = 1'b1;
    for (int k = 0; k < 20000 && txlog.size() < base + 227; k++) @(negedge clk);
    echo_en = 1'b0;
    repeat (8) @(negedge clk);
    chk("wrap_cnt", echo_count, 0);
    ack_dly = 6;
    rxq.push_back(8'h5A);
    exp_rx.push_back(8'h5A);
    tx0 = txlog.size();
    echo_en = 1'b1;
    for (int k = 0; k < 300 && !(cyc && we && adr == 5'd0); k++) @(negedge clk);
    chk("mid_thr_seen", cyc && we && adr == 5'd0, 1);
    echo_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_cyc", cyc, 0);
    chk("mid_stb", stb, 0);
    chk("mid_cnt", echo_count, 0);
    repeat (2) @(negedge clk);
    chk("mid_no_thr", txlog.size(), tx0);
    no_ack_dlm = 1'b1;
    ack_dly = 0;
    alog.delete();
    rst = 1'b0;
    for (int k = 0; k < 100 && !(cyc && we && adr == 5'd1); k++) @(negedge clk);
    chk("tmo_dlm_seen", cyc && we && adr == 5'd1, 1);
    n = 0;
    while (cyc && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_len", n, 16);
    chk("tmo_err", bus_err, 1);
    for (int k = 0; k < 200 && !init_done; k++) @(negedge clk);
    chk("tmo_done", init_done, 1);
    chk("tmo_n", alog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < alog.size())
        chk($sformatf("tmo_init%0d", i), {alog[i].adr, alog[i].dat},
            {init_tab[i < 2 ? i : i + 1].adr, init_tab[i < 2 ? i : i + 1].dat});
    repeat (10) @(negedge clk);
    chk("err_sticky", bus_err, 1);
    chk("rx_left", exp_rx.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
